// File: rtl/nes_pkg.sv
// Shared constants for the NES pad responder: button bit positions, frame
// length and the responder FSM state encoding.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NES_BITS = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // One host clock: drop bit 0 and fill from the top with a pressed (1) level,
  // so a drained frame reads as all-pressed on the wire, like a CD4021 pad.
  function automatic logic [NES_BITS-1:0] shift_fill(input logic [NES_BITS-1:0] v);
    return {1'b1, v[NES_BITS-1:1]};
  endfunction

endpackage

// File: rtl/nes_input_sync.sv
// Multi-flop synchroniser for one asynchronous host pin, followed by a
// registered one-cycle rise/fall pulse pair.
module nes_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~prev;
      fall <= ~sync[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/nes_controller_tx.sv
// Pad-side responder of the NES serial protocol: captures buttons on latch,
// shifts them out active-low A-first on host clock rises, then holds low.
module nes_controller_tx
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons,
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic       busy,
  output logic [3:0] bits_sent,
  output logic [7:0] snapshot,
  output logic       frame_done,
  output logic       timeout
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     state;
  logic [7:0]     shift_reg;
  logic [TCW-1:0] tcnt;

  logic latch_rise, latch_fall, clk_rise, clk_fall;
  logic any_edge, counting, timeout_hit;

  nes_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (nes_latch),
    .rise (latch_rise),
    .fall (latch_fall)
  );

  nes_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (nes_clk),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  assign busy        = (state != IDLE);
  assign any_edge    = latch_rise | latch_fall | clk_rise | clk_fall;
  assign counting    = (state == SHIFT) || (state == DRAIN);
  assign timeout_hit = counting && !any_edge && (tcnt == TC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      snapshot   <= '0;
      bits_sent  <= '0;
      nes_data   <= 1'b1;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      tcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= 1'b0;

      // Any host activity restarts the idle timer; it only runs mid-frame.
      if (any_edge || !counting || timeout_hit) tcnt <= '0;
      else                                      tcnt <= tcnt + TCW'(1);

      if (latch_rise) begin
        // A new latch always wins, including over a same-cycle clock rise.
        state     <= LOAD;
        shift_reg <= buttons;
        nes_data  <= ~buttons[BTN_A];
      end else begin
        case (state)
          IDLE: begin
            nes_data <= 1'b1;
          end
          LOAD: begin
            shift_reg <= buttons;
            nes_data  <= ~buttons[BTN_A];
            if (latch_fall) begin
              state     <= SHIFT;
              snapshot  <= buttons;
              bits_sent <= '0;
            end
          end
          SHIFT: begin
            if (clk_rise) begin
              shift_reg <= shift_fill(shift_reg);
              nes_data  <= ~shift_reg[1];
              if (bits_sent == 4'(NES_BITS - 1)) begin
                bits_sent  <= 4'(NES_BITS);
                frame_done <= 1'b1;
                state      <= DRAIN;
              end else begin
                bits_sent <= bits_sent + 4'd1;
              end
            end else if (timeout_hit) begin
              state     <= IDLE;
              timeout   <= 1'b1;
              bits_sent <= '0;
              nes_data  <= 1'b1;
            end else begin
              nes_data <= ~shift_reg[0];
            end
          end
          DRAIN: begin
            if (timeout_hit) begin
              state     <= IDLE;
              timeout   <= 1'b1;
              bits_sent <= '0;
              nes_data  <= 1'b1;
            end else begin
              nes_data <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_controller_tx.sv
// Bench for nes_controller_tx: directed frame table, latch/clock corner
// sequences and randomized host traffic checked against a protocol model.
module tb_nes_controller_tx;

  localparam int S  = 2;
  localparam int TC = 25000;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FRAME = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       nes_latch = 1'b0;
  logic       nes_clk = 1'b0;
  logic       nes_data, busy, frame_done, timeout;
  logic [3:0] bits_sent;
  logic [7:0] snapshot;

  nes_controller_tx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buttons   (buttons),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .nes_data  (nes_data),
    .busy      (busy),
    .bits_sent (bits_sent),
    .snapshot  (snapshot),
    .frame_done(frame_done),
    .timeout   (timeout)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  logic chk_en = 1'b0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: pins seen S+1 cycles late, then frame rules on bit index.
  int         m_mode, m_idx, m_quiet;
  logic [7:0] m_snap;
  logic       m_wire, m_fd, m_to;
  logic [S+1:0] lat_h, clk_h;

  always @(posedge clk or negedge rst_n) begin
    logic lr, lf, cr, cf, anyev, tout;
    if (!rst_n) begin
      m_mode = M_IDLE; m_idx = 0; m_quiet = 0; m_snap = 8'h00;
      m_wire = 1'b1; m_fd = 1'b0; m_to = 1'b0;
      lat_h = '0; clk_h = '0;
    end else begin
      lr = lat_h[S] & ~lat_h[S+1];
      lf = ~lat_h[S] & lat_h[S+1];
      cr = clk_h[S] & ~clk_h[S+1];
      cf = ~clk_h[S] & clk_h[S+1];
      anyev = lr | lf | cr | cf;
      m_fd = 1'b0; m_to = 1'b0; tout = 1'b0;
      if (m_mode == M_FRAME && !anyev) begin
        if (m_quiet == TC - 1) begin tout = 1'b1; m_quiet = 0; end
        else m_quiet++;
      end else begin
        m_quiet = 0;
      end
      if (lr) begin
        m_mode = M_LOAD;
      end else if (m_mode == M_LOAD && lf) begin
        m_mode = M_FRAME; m_snap = buttons; m_idx = 0;
      end else if (m_mode == M_FRAME) begin
        if (tout) begin
          m_mode = M_IDLE; m_idx = 0; m_to = 1'b1;
        end else if (cr && m_idx < 8) begin
          m_idx++;
          if (m_idx == 8) m_fd = 1'b1;
        end
      end
      case (m_mode)
        M_IDLE:  m_wire = 1'b1;
        M_LOAD:  m_wire = ~buttons[0];
        default: m_wire = (m_idx < 8) ? ~m_snap[m_idx] : 1'b0;
      endcase
      lat_h = {lat_h[S:0], nes_latch};
      clk_h = {clk_h[S:0], nes_clk};
    end
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (chk_en)
      check("model", 32'({nes_data, busy, bits_sent, snapshot, frame_done, timeout}),
            32'({m_wire, (m_mode != M_IDLE), 4'(m_idx), m_snap, m_fd, m_to}));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_pulse(input int hi);
    nes_latch = 1'b1; idle(hi); nes_latch = 1'b0;
  endtask

  task automatic host_clk(input int half);
    nes_clk = 1'b1; idle(half); nes_clk = 1'b0; idle(half);
  endtask

  // Full-speed frame: 12 us latch, 6 us host clock; wire bit i read before rise i.
  task automatic run_frame(input logic [7:0] btn, input logic [8:0] wexp, input string name);
    buttons = btn;
    for (int i = 0; i < 9; i++) exp_q.push_back(wexp[i]);
    latch_pulse(300);
    idle(2);
    fd_cnt = 0;
    idle(73);
    for (int i = 0; i < 8; i++) begin
      check({name, "_wire"}, 32'(nes_data), 32'(exp_q.pop_front()));
      host_clk(75);
    end
    check({name, "_wire8"}, 32'(nes_data), 32'(exp_q.pop_front()));
    check({name, "_bits"}, 32'(bits_sent), 32'd8);
    check({name, "_snap"}, 32'(snapshot), 32'(btn));
    check({name, "_fdcnt"}, 32'(fd_cnt), 32'd1);
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [8:0] wire_exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int half;
    vecs[0] = '{8'h05, 9'b011111010};
    vecs[1] = '{8'hFF, 9'b000000000};
    vecs[2] = '{8'h00, 9'b011111111};
    vecs[3] = '{8'h80, 9'b001111111};
    vecs[4] = '{8'hA5, 9'b001011010};

    idle(2);
    check("in_reset", 32'({nes_data, busy, bits_sent, snapshot, frame_done, timeout}), 32'h8000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(3);
    check("reset_out", 32'({nes_data, busy, bits_sent, snapshot}), 32'h8000 >> 2);

    // Latch rise with A held: wire falls on the (S+1)th edge after first sample.
    buttons = 8'h01;
    nes_latch = 1'b1;
    idle(S + 1);
    check("latch_lat_before", 32'(nes_data), 32'd1);
    idle(1);
    check("latch_lat_after", 32'(nes_data), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    buttons[0] = 1'b0; idle(1);
    check("load_a0", 32'(nes_data), 32'd1);
    host_clk(4);
    buttons[0] = 1'b1; idle(1);
    check("load_a1", 32'(nes_data), 32'd0);
    host_clk(4); host_clk(4);
    buttons[0] = 1'b0; idle(1);
    check("load_a2", 32'(nes_data), 32'd1);
    check("load_bits", 32'(bits_sent), 32'd0);
    nes_latch = 1'b0;
    idle(10);

    for (int v = 0; v < 5; v++) run_frame(vecs[v].btn, vecs[v].wire_exp, $sformatf("vec%0d", v));

    // Abandoned frame: a latch after three bits restarts without frame_done.
    buttons = 8'hFF;
    latch_pulse(300); idle(20);
    fd_cnt = 0;
    repeat (3) host_clk(10);
    nes_latch = 1'b1;
    idle(S + 3);
    check("abort_state", 32'(dut.state), 32'(nes_pkg::LOAD));
    check("abort_bits", 32'(bits_sent), 32'd3);
    check("abort_fd", 32'(fd_cnt), 32'd0);
    idle(50);
    nes_latch = 1'b0;
    idle(20);
    run_frame(8'hFF, 9'b000000000, "after_abort");

    // Host goes silent mid-frame.
    buttons = 8'h80;
    latch_pulse(300); idle(20);
    host_clk(10);
    nes_clk = 1'b1; idle(10); nes_clk = 1'b0;
    n = 0;
    while (!timeout && n < 30000) begin @(negedge clk); n++; end
    check("timeout_cycles", 32'(n), 32'(S + TC + 2));
    check("timeout_out", 32'({busy, nes_data, bits_sent}), 32'b0_1_0000);
    check("timeout_snap", 32'(snapshot), 32'h80);
    idle(5);

    // Latch and clock rise together mid-frame: latch wins, clock is dropped.
    buttons = 8'h3C;
    latch_pulse(300); idle(20);
    repeat (3) host_clk(10);
    nes_latch = 1'b1; nes_clk = 1'b1;
    idle(S + 3);
    check("simul_bits", 32'(bits_sent), 32'd3);
    check("simul_state", 32'(dut.state), 32'(nes_pkg::LOAD));
    nes_clk = 1'b0; idle(10);
    nes_latch = 1'b0; idle(S + 3);
    check("simul_fall_bits", 32'(bits_sent), 32'd0);
    host_clk(6);
    check("simul_next_bit", 32'(bits_sent), 32'd1);
    idle(10);

    // Randomized host traffic, checked every cycle by the model.
    for (int it = 0; it < 80; it++) begin
      buttons = 8'($urandom);
      latch_pulse($urandom_range(1, 20));
      idle($urandom_range(1, 10));
      n = $urandom_range(0, 11);
      half = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 5) == 0) buttons = 8'($urandom);
        if ($urandom_range(0, 15) == 0) nes_latch = 1'b1;
        host_clk(half);
        nes_latch = 1'b0;
      end
      idle($urandom_range(1, 12));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

endmodule
